xoroshiro128_stream: RTL and testbench
======================================

# xoroshiro128_stream

Parametrised xoroshiro128 generator with a selectable output scrambler (`+`, `++`, `**`), valid/ready backpressure, runtime reseeding and a hardware jump-ahead of 2^64 steps. It is the next-generation PRNG source for the design. Independent per-consumer streams are obtained by seeding identically and jumping. State advances only when an output word is consumed, so the sequence is deterministic regardless of consumer stalls.

## Interface
- `SCRAMBLER`, default `PLUS`: output function; one of `PLUS`, `PLUSPLUS`, `STARSTAR`.
- `OUT_W`, default 64: output width, 1..64; `out_data` = upper `OUT_W` bits of the 64-bit scrambled word.
- `SEED0`, default 64'h1: reset value of s0.
- `SEED1`, default 64'h0: reset value of s1.

Ports (name, direction, width, meaning):
- `clk`  in  1  the single clock.
- `resn`  in  1  asynchronous, active-low reset.
- `seed_load`  in  1  one-cycle request to load `seed_s0`/`seed_s1`.
- `seed_s0`  in  64  new s0, sampled when `seed_load` = 1.
- `seed_s1`  in  64  new s1, sampled when `seed_load` = 1.
- `jump_req`  in  1  one-cycle request to advance the state by 2^64 steps.
- `busy`  out  1  high while not in RUN.
- `out_valid`  out  1  `out_data` holds an unconsumed word.
- `out_ready`  in  1  consumer accepts `out_data` when `out_valid` = 1.
- `out_data`  out  `OUT_W`  scrambled output word.

## Operation
- Engine uses rotation constants (55, 14, 36):
  - sx = s0^s1
  - s0' = rotl(s0,55) ^ sx ^ (sx<<14)
  - s1' = rotl(sx,36)
- Scramblers, computed mod 2^64:
  - `PLUS`: s0+s1
  - `PLUSPLUS`: rotl(s0+s1,17)+s0
  - `STARSTAR`: rotl(s0*5,7)*9
- FSM states: PRIME, RUN, JUMP.
- Reset values:
  - state = PRIME; s0 = SEED0, s1 = SEED1; acc = 0; cnt = 0.
  - `out_valid` = 0; `out_data` = 0; `busy` = 1.
  - If SEED0 = SEED1 = 0, the reset state is s0 = 1, s1 = 0.
- PRIME (one cycle): `out_data` <= scramble(s); s <= next(s); `out_valid` <= 1; go to RUN.
- RUN, transfer (`out_valid` & `out_ready`): `out_data` <= scramble(s); s <= next(s). Otherwise everything holds.
- Seed load: on `seed_load` in any state, s <= {`seed_s0`, `seed_s1`}; `out_valid` <= 0; go to PRIME.
  - An all-zero seed is replaced by s0 = 1, s1 = 0.
  - A load during JUMP aborts the jump.
- Jump start: on `jump_req` in RUN, acc <= 0; cnt <= 0; `out_valid` <= 0; go to JUMP. The pending word is discarded.
- JUMP, each cycle:
  - If J[cnt] = 1, acc ^= {s0, s1}.
  - s <= next(s); cnt++.
  - J = {64'hd86b048b86aa9922, 64'hbeac0467eba5facb}; bit 0 is the LSB of 0xbeac...
  - On cnt = 127, s <= final acc and go to PRIME.
- `jump_req` outside RUN is ignored.
- Priority in one cycle: `seed_load` > `jump_req` > transfer. A transfer coinciding with `seed_load` or `jump_req` is not counted as consumed.

## Timing
- First word: `out_valid` = 1 after the first rising edge following reset release; the first word is scramble(SEED).
- Throughput: one word per cycle while `out_ready` = 1. Zero-bubble: `out_valid` stays high across back-to-back transfers.
- Seed latency: `seed_load` at edge N gives `out_valid` at edge N+2 (N+1 loads, N+2 primes).
- Jump latency: `jump_req` at edge N; JUMP spans edges N+1..N+128; PRIME at N+129; `out_valid` = 1 after N+129.
- While `out_valid` = 1 and `out_ready` = 0, `out_data` is stable.
- Reset may assert mid-JUMP or mid-stall; the block returns to reset values immediately.

## Structure
- Package `xoro_pkg`, shared with the existing generator:
  - scrambler enum;
  - rotation constants 55/14/36;
  - jump constant J;
  - `xoro_next` function.
- Sub-module `xoro_scramble`: combinational, parameter `SCRAMBLER`, 128-bit state in, 64-bit word out.
- Top holds the FSM, state registers, acc/cnt and the output register.

## Test plan
- Reset, `PLUS`, default seed, `out_ready` = 1 → words 0x0000000000000001, 0x0080001000004001, then match the C reference for 1000 words.
- `PLUSPLUS` first word 0x0000000000020001; `STARSTAR` first word 0x0000000000001680; `OUT_W` = 32 yields the upper half of each.
- Random `out_ready` stalls → `out_data` stable while stalled; the consumed sequence is identical to the unstalled run, with no duplicates or skips.
- `jump_req` from seed {1,0} → `busy` for 129 cycles; `out_valid` after 130 edges; the word equals the C `jump()` reference followed by scramble.
- `seed_load` of all zeros, then `seed_load` at JUMP cycle 60 with {5,7} → first case yields state {1,0}; the second aborts the jump and the first word is 0x000000000000000C (`PLUS`).
- Simultaneous `seed_load`, `jump_req` and transfer → seed wins and no jump follows; reset asserted mid-JUMP gives `out_valid` = 0 and `out_data` = 0 asynchronously.

Source files
------------

// File: rtl/xoro_pkg.sv
// Shared xoroshiro128 definitions: scrambler selection, engine constants,
// jump polynomial and the single-step state advance.
package xoro_pkg;

    typedef enum logic [1:0] {
        PLUS,
        PLUSPLUS,
        STARSTAR
    } scrambler_e;

    typedef enum logic [1:0] {
        ST_PRIME,
        ST_RUN,
        ST_JUMP
    } xoro_fsm_e;

    typedef struct packed {
        logic [63:0] s0;
        logic [63:0] s1;
    } xoro_state_t;

    localparam int unsigned XORO_W     = 64;
    localparam int unsigned ROT_A      = 55;
    localparam int unsigned ROT_B      = 14;
    localparam int unsigned ROT_C      = 36;
    localparam int unsigned JUMP_STEPS = 128;
    localparam int unsigned CNT_W      = 7;

    // Bit i selects whether the state after i steps contributes to the jump result.
    localparam logic [127:0] JUMP_POLY = {64'hd86b048b86aa9922, 64'hbeac0467eba5facb};

    function automatic logic [63:0] rotl64(input logic [63:0] x, input int unsigned n);
        return (x << n) | (x >> (XORO_W - n));
    endfunction

    function automatic xoro_state_t xoro_next(input xoro_state_t s);
        logic [63:0] sx;
        xoro_state_t n;
        sx   = s.s0 ^ s.s1;
        n.s0 = rotl64(s.s0, ROT_A) ^ sx ^ (sx << ROT_B);
        n.s1 = rotl64(sx, ROT_C);
        return n;
    endfunction

endpackage

// File: rtl/xoro_scramble.sv
// Combinational output scrambler for the xoroshiro128 state.
module xoro_scramble
    import xoro_pkg::*;
#(
    parameter scrambler_e SCRAMBLER = PLUS
) (
    input  xoro_state_t s,
    output logic [63:0] word_c
);

    logic [63:0] sum;
    logic [63:0] x5;
    logic [63:0] r7;

    // Constant multiplies by 5 and 9 written as shift-and-add.
    always_comb begin
        sum    = s.s0 + s.s1;
        x5     = (s.s0 << 2) + s.s0;
        r7     = rotl64(x5, 7);
        word_c = sum;
        case (SCRAMBLER)
            PLUSPLUS: word_c = rotl64(sum, 17) + s.s0;
            STARSTAR: word_c = (r7 << 3) + r7;
            default:  word_c = sum;
        endcase
    end

endmodule

// File: rtl/xoroshiro128_stream.sv
// xoroshiro128 stream source: valid/ready output, runtime reseed and a
// sequential 2^64-step jump-ahead driven by the jump polynomial.
module xoroshiro128_stream
    import xoro_pkg::*;
#(
    parameter scrambler_e  SCRAMBLER = PLUS,
    parameter int unsigned OUT_W     = 64,
    parameter logic [63:0] SEED0     = 64'h1,
    parameter logic [63:0] SEED1     = 64'h0
) (
    input  logic             clk,
    input  logic             resn,
    input  logic             seed_load,
    input  logic [63:0]      seed_s0,
    input  logic [63:0]      seed_s1,
    input  logic             jump_req,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data
);

    // The all-zero state is a fixed point of the engine, so it is never allowed in.
    localparam logic [63:0] RST_S0 = ((SEED0 == 64'h0) && (SEED1 == 64'h0)) ? 64'h1 : SEED0;
    localparam logic [63:0] RST_S1 = SEED1;

    xoro_fsm_e         state_q, state_d;
    xoro_state_t       s_q, s_d;
    xoro_state_t       acc_q, acc_d;
    xoro_state_t       acc_x;
    xoro_state_t       s_next;
    xoro_state_t       seed_fix;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              valid_d;
    logic              busy_d;
    logic [OUT_W-1:0]  data_d;
    logic [63:0]       word_c;
    logic              jbit;

    xoro_scramble #(
        .SCRAMBLER (SCRAMBLER)
    ) u_scramble (
        .s      (s_q),
        .word_c (word_c)
    );

    always_comb begin
        s_next = xoro_next(s_q);
        if ((seed_s0 == 64'h0) && (seed_s1 == 64'h0)) begin
            seed_fix.s0 = 64'h1;
            seed_fix.s1 = 64'h0;
        end else begin
            seed_fix.s0 = seed_s0;
            seed_fix.s1 = seed_s1;
        end
        jbit     = JUMP_POLY[cnt_q];
        acc_x.s0 = acc_q.s0 ^ (jbit ? s_q.s0 : 64'h0);
        acc_x.s1 = acc_q.s1 ^ (jbit ? s_q.s1 : 64'h0);
    end

    // Next-state and datapath update; seed_load > jump_req > transfer.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        valid_d = out_valid;
        data_d  = out_data;
        if (seed_load) begin
            s_d     = seed_fix;
            valid_d = 1'b0;
            state_d = ST_PRIME;
        end else begin
            case (state_q)
                ST_PRIME: begin
                    data_d  = OUT_W'(word_c >> (XORO_W - OUT_W));
                    s_d     = s_next;
                    valid_d = 1'b1;
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (jump_req) begin
                        acc_d   = '0;
                        cnt_d   = '0;
                        valid_d = 1'b0;
                        state_d = ST_JUMP;
                    end else if (out_valid && out_ready) begin
                        data_d = OUT_W'(word_c >> (XORO_W - OUT_W));
                        s_d    = s_next;
                    end
                end
                ST_JUMP: begin
                    acc_d = acc_x;
                    cnt_d = CNT_W'(cnt_q + 1);
                    if (cnt_q == CNT_W'(JUMP_STEPS - 1)) begin
                        s_d     = acc_x;
                        state_d = ST_PRIME;
                    end else begin
                        s_d = s_next;
                    end
                end
                default: begin
                    valid_d = 1'b0;
                    state_d = ST_PRIME;
                end
            endcase
        end
        busy_d = (state_d != ST_RUN);
    end

    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            state_q   <= ST_PRIME;
            s_q.s0    <= RST_S0;
            s_q.s1    <= RST_S1;
            acc_q     <= '0;
            cnt_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b1;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            out_valid <= valid_d;
            out_data  <= data_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_xoroshiro128_stream.sv
// Scoreboard bench: stimulus pushes reference states, a monitor checks every
// presented word of three scrambler variants against them.
module tb_xoroshiro128_stream;
    import xoro_pkg::*;

    logic        clk = 1'b0;
    logic        resn;
    logic        seed_load;
    logic [63:0] seed_s0;
    logic [63:0] seed_s1;
    logic        jump_req;
    logic        out_ready;
    logic        busy, busy_pp, busy_ss;
    logic        out_valid, valid_pp, valid_ss;
    logic [63:0] out_data, data_pp;
    logic [31:0] data_ss;

    int n_cmp = 0;
    int n_bad = 0;
    logic [127:0] q[$];
    logic [127:0] mon_st;
    logic [63:0]  mon_ss;

    always #5 clk = ~clk;

    xoroshiro128_stream #(.SCRAMBLER(PLUS), .OUT_W(64)) dut (
        .clk(clk), .resn(resn), .seed_load(seed_load), .seed_s0(seed_s0), .seed_s1(seed_s1),
        .jump_req(jump_req), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data));

    xoroshiro128_stream #(.SCRAMBLER(PLUSPLUS), .OUT_W(64)) dut_pp (
        .clk(clk), .resn(resn), .seed_load(seed_load), .seed_s0(seed_s0), .seed_s1(seed_s1),
        .jump_req(jump_req), .busy(busy_pp), .out_valid(valid_pp), .out_ready(out_ready),
        .out_data(data_pp));

    xoroshiro128_stream #(.SCRAMBLER(STARSTAR), .OUT_W(32)) dut_ss (
        .clk(clk), .resn(resn), .seed_load(seed_load), .seed_s0(seed_s0), .seed_s1(seed_s1),
        .jump_req(jump_req), .busy(busy_ss), .out_valid(valid_ss), .out_ready(out_ready),
        .out_data(data_ss));

    // Reference model on a {s0, s1} vector.
    function automatic logic [63:0] rotl(input logic [63:0] x, input int n);
        return (x << n) | (x >> (64 - n));
    endfunction

    function automatic logic [127:0] mnext(input logic [127:0] s);
        logic [63:0] a = s[127:64];
        logic [63:0] b = s[63:0];
        logic [63:0] x = a ^ b;
        return {rotl(a, 55) ^ x ^ (x << 14), rotl(x, 36)};
    endfunction

    function automatic logic [127:0] mjump(input logic [127:0] s_in);
        logic [127:0] jc  = {64'hd86b048b86aa9922, 64'hbeac0467eba5facb};
        logic [127:0] acc = '0;
        logic [127:0] s   = s_in;
        for (int i = 0; i < 128; i++) begin
            if (jc[i]) acc ^= s;
            s = mnext(s);
        end
        return acc;
    endfunction

    function automatic logic [63:0] fplus(input logic [127:0] s);
        return s[127:64] + s[63:0];
    endfunction

    function automatic logic [63:0] fpp(input logic [127:0] s);
        return rotl(s[127:64] + s[63:0], 17) + s[127:64];
    endfunction

    function automatic logic [63:0] fss(input logic [127:0] s);
        logic [63:0] m = s[127:64] * 64'd5;
        return rotl(m, 7) * 64'd9;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic load_model(input logic [127:0] st, input int n);
        logic [127:0] s = st;
        for (int i = 0; i < n; i++) begin
            q.push_back(s);
            s = mnext(s);
        end
    endtask

    // Monitor: every presented word must match the queue front; pop on a real transfer.
    always @(negedge clk) begin
        if (resn && out_valid && !seed_load && !jump_req) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_word: got %h with no expectation queued", out_data);
            end else begin
                mon_st = q[0];
                mon_ss = fss(mon_st);
                check("word_plus", out_data, fplus(mon_st));
                check("word_pp", data_pp, fpp(mon_st));
                check("word_ss_hi32", 64'(data_ss), 64'(mon_ss[63:32]));
                check("aux_flags", 64'({valid_pp, valid_ss, busy_pp, busy_ss}), 64'h0c);
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    // Consume until only the last expected word remains, then stall on it.
    task automatic drain(input bit rnd, input int budget);
        int cyc = 0;
        while (q.size() > 1 && cyc < budget) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b0;
        check("drain_done", 64'(q.size() <= 1), 64'h1);
    endtask

    task automatic issue_seed(input logic [63:0] a, input logic [63:0] b, input int n);
        logic [127:0] st = ((a == 64'h0) && (b == 64'h0)) ? {64'h1, 64'h0} : {a, b};
        q.delete();
        load_model(st, n);
        seed_s0 = a;
        seed_s1 = b;
        seed_load = 1'b1;
        @(posedge clk); #1;
        seed_load = 1'b0;
        check("seed_valid_low", 64'(out_valid), 64'h0);
        check("seed_busy_high", 64'(busy), 64'h1);
        @(posedge clk); #1;
        check("seed_valid_high", 64'(out_valid), 64'h1);
        check("seed_busy_low", 64'(busy), 64'h0);
    endtask

    task automatic issue_jump(input int n);
        logic [127:0] st;
        int bcnt = 0;
        if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL jump_setup: got empty queue expected pending word");
            st = {64'h1, 64'h0};
        end else begin
            st = q[0];
        end
        q.delete();
        load_model(mjump(mnext(st)), n);
        jump_req = 1'b1;
        @(posedge clk); #1;
        jump_req = 1'b0;
        while (busy && bcnt < 300) begin
            check("jump_no_valid", 64'(out_valid), 64'h0);
            bcnt++;
            @(posedge clk); #1;
        end
        check("jump_busy_cycles", 64'(bcnt), 64'd129);
        check("jump_valid_after", 64'(out_valid), 64'h1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resn = 1'b0; seed_load = 1'b0; jump_req = 1'b0; out_ready = 1'b0;
        seed_s0 = '0; seed_s1 = '0;
        #12;
        check("rst_valid", 64'(out_valid), 64'h0);
        check("rst_data", out_data, 64'h0);
        check("rst_busy", 64'(busy), 64'h1);
        load_model({64'h1, 64'h0}, 1000);
        @(posedge clk); #1;
        resn = 1'b1;
        @(posedge clk); #1;
        check("first_plus", out_data, 64'h0000000000000001);
        check("first_pp", data_pp, 64'h0000000000020001);
        check("first_ss_hi", 64'(data_ss), 64'h0);
        check("first_busy", 64'(busy), 64'h0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("second_plus", out_data, 64'h0080001000004001);
        drain(1'b0, 1100);

        // Random seeds consumed under random stalls.
        for (int k = 0; k < 2; k++) begin
            issue_seed({$urandom, $urandom}, {$urandom, $urandom}, 200);
            drain(1'b1, 2000);
        end

        // Zero seed is replaced by {1,0}.
        issue_seed(64'h0, 64'h0, 10);
        check("zero_seed_word", out_data, 64'h1);
        drain(1'b1, 200);

        // Jump from the reset seed, then a jump from a random state.
        issue_seed(64'h1, 64'h0, 5);
        issue_jump(50);
        drain(1'b1, 500);
        issue_seed({$urandom, $urandom}, {$urandom, $urandom}, 20);
        drain(1'b1, 200);
        issue_jump(100);
        drain(1'b1, 1000);

        // Seed load 60 cycles into a jump aborts it.
        q.delete();
        jump_req = 1'b1;
        @(posedge clk); #1;
        jump_req = 1'b0;
        repeat (60) begin @(posedge clk); #1; end
        check("abort_busy", 64'(busy), 64'h1);
        issue_seed(64'h5, 64'h7, 30);
        check("abort_word", out_data, 64'h000000000000000C);
        drain(1'b1, 300);

        // Seed, jump and transfer in the same cycle: the seed wins, no jump.
        seed_s0 = {$urandom, $urandom};
        seed_s1 = {$urandom, $urandom};
        q.delete();
        load_model({seed_s0, seed_s1}, 30);
        seed_load = 1'b1; jump_req = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        seed_load = 1'b0; jump_req = 1'b0; out_ready = 1'b0;
        check("simul_valid_low", 64'(out_valid), 64'h0);
        @(posedge clk); #1;
        check("simul_valid_high", 64'(out_valid), 64'h1);
        repeat (3) begin @(posedge clk); #1; end
        check("simul_no_jump", 64'(busy), 64'h0);
        drain(1'b1, 300);

        // Asynchronous reset in the middle of a jump.
        q.delete();
        jump_req = 1'b1;
        @(posedge clk); #1;
        jump_req = 1'b0;
        repeat (40) @(posedge clk);
        #3;
        resn = 1'b0;
        #1;
        check("midjump_rst_valid", 64'(out_valid), 64'h0);
        check("midjump_rst_data", out_data, 64'h0);
        check("midjump_rst_busy", 64'(busy), 64'h1);
        load_model({64'h1, 64'h0}, 40);
        @(posedge clk); #1;
        resn = 1'b1;
        @(posedge clk); #1;
        check("post_rst_word", out_data, 64'h1);
        drain(1'b1, 400);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
